kb_field_editor: RTL and testbench

//  Parametrised successor of the PS/2 keyboard editing controller for the clock/timer system.

---
 rtl/kb_field_editor.sv | 149 ++++++++++++++
 tb/tb_kb_field_editor.sv | 130 +++++++++++++
 2 files changed

// File: rtl/kb_field_editor.sv
// kb_field_editor: PS/2 scan-code driven editor for date/clock/timer registers; one cycle per accepted key.
// While a commit is pending every new key is discarded (key_drop pulse) until commit_ack.
module kb_field_editor #(
  parameter int                DIGITS     = 2,
  parameter int                ADDR_W     = 8,
  parameter int                FIELDS     = 3,
  parameter logic [ADDR_W-1:0] BASE_DATE  = 8'd22,
  parameter logic [ADDR_W-1:0] BASE_CLOCK = 8'd19,
  parameter logic [ADDR_W-1:0] BASE_TIMER = 8'd25,
  parameter logic [ADDR_W-1:0] ALARM_ADDR = 8'd28,
  parameter logic [7:0]        ALARM_ON   = 8'h08,
  localparam int               DW         = 4 * DIGITS,
  localparam int               FW         = (FIELDS > 1) ? $clog2(FIELDS) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [15:0]       scan_code,
  input  logic              scan_valid,
  input  logic              commit_ack,
  output logic [ADDR_W-1:0] addr,
  output logic [DW-1:0]     data,
  output logic              commit_req,
  output logic [1:0]        mode,
  output logic [FW-1:0]     field_idx,
  output logic              key_drop
);

  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

  state_t        state;
  logic [CW-1:0] digit_cnt;

  logic [7:0] prev_byte;
  logic [7:0] cur_byte;
  logic       is_make;
  logic       is_break;
  logic [4:0] dig;

  assign prev_byte = scan_code[15:8];
  assign cur_byte  = scan_code[7:0];
  assign is_break  = (prev_byte == 8'hF0);
  assign is_make   = (prev_byte != 8'hF0) && (prev_byte != 8'hE0);

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] m);
    case (m)
      2'd1:    return BASE_DATE;
      2'd2:    return BASE_CLOCK;
      2'd3:    return BASE_TIMER;
      default: return '0;
    endcase
  endfunction

  // {valid, value}: main-row and keypad digits share one decoder
  function automatic logic [4:0] digit_of(input logic [7:0] c);
    case (c)
      8'h45, 8'h70: return {1'b1, 4'd0};
      8'h16, 8'h69: return {1'b1, 4'd1};
      8'h1E, 8'h72: return {1'b1, 4'd2};
      8'h26, 8'h7A: return {1'b1, 4'd3};
      8'h25, 8'h6B: return {1'b1, 4'd4};
      8'h2E, 8'h73: return {1'b1, 4'd5};
      8'h36, 8'h74: return {1'b1, 4'd6};
      8'h3D, 8'h6C: return {1'b1, 4'd7};
      8'h3E, 8'h75: return {1'b1, 4'd8};
      8'h46, 8'h7D: return {1'b1, 4'd9};
      default:      return 5'd0;
    endcase
  endfunction

  assign dig = digit_of(cur_byte);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      addr       <= '0;
      data       <= '0;
      commit_req <= 1'b0;
      mode       <= 2'd0;
      field_idx  <= '0;
      digit_cnt  <= '0;
      key_drop   <= 1'b0;
    end else begin
      key_drop <= 1'b0;
      if (state == S_COMMIT) begin
        if (scan_valid) key_drop <= 1'b1;
        if (commit_ack) begin
          state      <= S_IDLE;
          addr       <= '0;
          data       <= '0;
          commit_req <= 1'b0;
          mode       <= 2'd0;
          field_idx  <= '0;
          digit_cnt  <= '0;
        end
      end else if (scan_valid) begin
        if (is_break && cur_byte == 8'h76) begin
          state      <= S_IDLE;
          addr       <= '0;
          data       <= '0;
          commit_req <= 1'b0;
          mode       <= 2'd0;
          field_idx  <= '0;
          digit_cnt  <= '0;
        end else if (is_make) begin
          case (cur_byte)
            8'h05, 8'h06, 8'h04: begin
              state     <= S_EDIT;
              mode      <= (cur_byte == 8'h05) ? 2'd1 : (cur_byte == 8'h06) ? 2'd2 : 2'd3;
              addr      <= (cur_byte == 8'h05) ? BASE_DATE :
                           (cur_byte == 8'h06) ? BASE_CLOCK : BASE_TIMER;
              field_idx <= '0;
              data      <= '0;
              digit_cnt <= '0;
            end
            8'h0D: if (state == S_EDIT) begin
              if (field_idx == FW'(FIELDS - 1)) begin
                field_idx <= '0;
                addr      <= base_of(mode);
              end else begin
                field_idx <= field_idx + FW'(1);
                addr      <= addr - ADDR_W'(1);
              end
              data      <= '0;
              digit_cnt <= '0;
            end
            8'h5A: if (state == S_EDIT) begin
              state      <= S_COMMIT;
              commit_req <= 1'b1;
            end
            8'h78, 8'h07: begin
              addr       <= ALARM_ADDR;
              data       <= (cur_byte == 8'h78) ? DW'(ALARM_ON) : '0;
              state      <= S_COMMIT;
              commit_req <= 1'b1;
            end
            default: if (state == S_EDIT && dig[4]) begin
              // oldest digit falls off the top of the buffer
              data <= (data << 4) | DW'(dig[3:0]);
              if (digit_cnt != CW'(DIGITS)) digit_cnt <= digit_cnt + CW'(1);
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_kb_field_editor.sv
// Directed vector bench for kb_field_editor: one key (or idle) per vector, outputs checked a cycle later.
module tb_kb_field_editor;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] scan_code = '0;
  logic        scan_valid = 1'b0;
  logic        commit_ack = 1'b0;
  logic [7:0]  addr;
  logic [7:0]  data;
  logic        commit_req;
  logic [1:0]  mode;
  logic [1:0]  field_idx;
  logic        key_drop;

  int n_vec = 0;
  int n_err = 0;

  kb_field_editor dut (
    .CLK(CLK), .RESET(RESET), .scan_code(scan_code), .scan_valid(scan_valid),
    .commit_ack(commit_ack), .addr(addr), .data(data), .commit_req(commit_req),
    .mode(mode), .field_idx(field_idx), .key_drop(key_drop)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        sv;
    logic [15:0] code;
    logic        ack;
    logic [7:0]  e_addr;
    logic [7:0]  e_data;
    logic        e_req;
    logic [1:0]  e_mode;
    logic [1:0]  e_fidx;
    logic        e_drop;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic sv, input logic [15:0] code, input logic ack,
                              input logic [7:0] a, input logic [7:0] d, input logic r,
                              input logic [1:0] m, input logic [1:0] f, input logic k);
    vec_t v;
    v.sv = sv; v.code = code; v.ack = ack;
    v.e_addr = a; v.e_data = d; v.e_req = r; v.e_mode = m; v.e_fidx = f; v.e_drop = k;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] a, input logic [7:0] d, input logic r,
                       input logic [1:0] m, input logic [1:0] f, input logic k);
    n_vec++;
    if ({addr, data, commit_req, mode, field_idx, key_drop} !== {a, d, r, m, f, k}) begin
      n_err++;
      $display("FAIL %s: got addr=%0d data=%h req=%b mode=%0d fidx=%0d drop=%b, expected addr=%0d data=%h req=%b mode=%0d fidx=%0d drop=%b",
               nm, addr, data, commit_req, mode, field_idx, key_drop, a, d, r, m, f, k);
    end
  endtask

  // called at a negedge: drive, let one posedge pass, check at the following negedge
  task automatic apply(input string nm, input vec_t v);
    scan_valid = v.sv;
    scan_code  = v.code;
    commit_ack = v.ack;
    @(posedge CLK);
    @(negedge CLK);
    scan_valid = 1'b0;
    commit_ack = 1'b0;
    check(nm, v.e_addr, v.e_data, v.e_req, v.e_mode, v.e_fidx, v.e_drop);
  endtask

  initial begin
    //                sv    code      ack   addr   data   req   mode  fidx  drop
    vq.push_back(mk(1'b1, 16'h0006, 1'b0, 8'd19, 8'h00, 1'b0, 2'd2, 2'd0, 1'b0)); // F2
    vq.push_back(mk(1'b1, 16'h0016, 1'b0, 8'd19, 8'h01, 1'b0, 2'd2, 2'd0, 1'b0)); // 1
    vq.push_back(mk(1'b1, 16'h001E, 1'b0, 8'd19, 8'h12, 1'b0, 2'd2, 2'd0, 1'b0)); // 2
    vq.push_back(mk(1'b0, 16'h001E, 1'b0, 8'd19, 8'h12, 1'b0, 2'd2, 2'd0, 1'b0)); // idle
    vq.push_back(mk(1'b1, 16'h005A, 1'b0, 8'd19, 8'h12, 1'b1, 2'd2, 2'd0, 1'b0)); // Enter
    vq.push_back(mk(1'b0, 16'h0000, 1'b1, 8'd0,  8'h00, 1'b0, 2'd0, 2'd0, 1'b0)); // ack
    vq.push_back(mk(1'b1, 16'h005A, 1'b0, 8'd0,  8'h00, 1'b0, 2'd0, 2'd0, 1'b0)); // Enter idle
    vq.push_back(mk(1'b1, 16'h0045, 1'b0, 8'd0,  8'h00, 1'b0, 2'd0, 2'd0, 1'b0)); // digit idle
    vq.push_back(mk(1'b1, 16'h000D, 1'b0, 8'd0,  8'h00, 1'b0, 2'd0, 2'd0, 1'b0)); // Tab idle
    vq.push_back(mk(1'b1, 16'h0005, 1'b0, 8'd22, 8'h00, 1'b0, 2'd1, 2'd0, 1'b0)); // F1
    vq.push_back(mk(1'b1, 16'h006C, 1'b0, 8'd22, 8'h07, 1'b0, 2'd1, 2'd0, 1'b0)); // kp 7
    vq.push_back(mk(1'b1, 16'h000D, 1'b0, 8'd21, 8'h00, 1'b0, 2'd1, 2'd1, 1'b0)); // Tab
    vq.push_back(mk(1'b1, 16'h000D, 1'b0, 8'd20, 8'h00, 1'b0, 2'd1, 2'd2, 1'b0)); // Tab
    vq.push_back(mk(1'b1, 16'h000D, 1'b0, 8'd22, 8'h00, 1'b0, 2'd1, 2'd0, 1'b0)); // Tab wrap
    vq.push_back(mk(1'b1, 16'h0004, 1'b0, 8'd25, 8'h00, 1'b0, 2'd3, 2'd0, 1'b0)); // F3
    vq.push_back(mk(1'b1, 16'h0025, 1'b0, 8'd25, 8'h04, 1'b0, 2'd3, 2'd0, 1'b0)); // 4
    vq.push_back(mk(1'b1, 16'h002E, 1'b0, 8'd25, 8'h45, 1'b0, 2'd3, 2'd0, 1'b0)); // 5
    vq.push_back(mk(1'b1, 16'h007D, 1'b0, 8'd25, 8'h59, 1'b0, 2'd3, 2'd0, 1'b0)); // kp 9
    vq.push_back(mk(1'b1, 16'hF045, 1'b0, 8'd25, 8'h59, 1'b0, 2'd3, 2'd0, 1'b0)); // 0 break
    vq.push_back(mk(1'b1, 16'h0076, 1'b0, 8'd25, 8'h59, 1'b0, 2'd3, 2'd0, 1'b0)); // Esc make
    vq.push_back(mk(1'b0, 16'h0000, 1'b1, 8'd25, 8'h59, 1'b0, 2'd3, 2'd0, 1'b0)); // stray ack
    vq.push_back(mk(1'b1, 16'hE05A, 1'b0, 8'd25, 8'h59, 1'b0, 2'd3, 2'd0, 1'b0)); // E0 5A
    vq.push_back(mk(1'b1, 16'h001C, 1'b0, 8'd25, 8'h59, 1'b0, 2'd3, 2'd0, 1'b0)); // unlisted
    vq.push_back(mk(1'b1, 16'hF076, 1'b0, 8'd0,  8'h00, 1'b0, 2'd0, 2'd0, 1'b0)); // Esc break
    vq.push_back(mk(1'b1, 16'h0078, 1'b0, 8'd28, 8'h08, 1'b1, 2'd0, 2'd0, 1'b0)); // F11
    vq.push_back(mk(1'b1, 16'h0016, 1'b0, 8'd28, 8'h08, 1'b1, 2'd0, 2'd0, 1'b1)); // key in commit
    vq.push_back(mk(1'b1, 16'hF076, 1'b0, 8'd28, 8'h08, 1'b1, 2'd0, 2'd0, 1'b1)); // Esc in commit
    vq.push_back(mk(1'b1, 16'h0005, 1'b1, 8'd0,  8'h00, 1'b0, 2'd0, 2'd0, 1'b1)); // key + ack
    vq.push_back(mk(1'b0, 16'h0000, 1'b0, 8'd0,  8'h00, 1'b0, 2'd0, 2'd0, 1'b0)); // drop clears
    vq.push_back(mk(1'b1, 16'h0006, 1'b0, 8'd19, 8'h00, 1'b0, 2'd2, 2'd0, 1'b0)); // F2
    vq.push_back(mk(1'b1, 16'h003D, 1'b0, 8'd19, 8'h07, 1'b0, 2'd2, 2'd0, 1'b0)); // 7
    vq.push_back(mk(1'b1, 16'h0007, 1'b0, 8'd28, 8'h00, 1'b1, 2'd2, 2'd0, 1'b0)); // F12
    vq.push_back(mk(1'b0, 16'h0000, 1'b1, 8'd0,  8'h00, 1'b0, 2'd0, 2'd0, 1'b0)); // ack

    repeat (3) @(negedge CLK);
    check("reset_held", 8'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
    RESET = 1'b0;
    @(negedge CLK);
    check("after_reset", 8'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);

    for (int i = 0; i < vq.size(); i++) apply($sformatf("vec%0d", i), vq[i]);

    // asynchronous reset while a commit is pending
    apply("async_f2",    mk(1'b1, 16'h0006, 1'b0, 8'd19, 8'h00, 1'b0, 2'd2, 2'd0, 1'b0));
    apply("async_enter", mk(1'b1, 16'h005A, 1'b0, 8'd19, 8'h00, 1'b1, 2'd2, 2'd0, 1'b0));
    #2 RESET = 1'b1;
    #1 check("async_reset", 8'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    apply("post_reset_enter", mk(1'b1, 16'h005A, 1'b0, 8'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0));
    apply("post_reset_f1",    mk(1'b1, 16'h0005, 1'b0, 8'd22, 8'h00, 1'b0, 2'd1, 2'd0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
